// File: rtl/npc_mem_pkg.sv
// Shared definitions for the memory responder.
//   state_e        : handshake FSM states (IDLE / WAIT / RESP)
//   RSP_ERR_*      : values driven on rsp_err
//   CNT_W          : width of the latency down-counter
//   byte_merge()   : byte-lane merge used by the storage write port
package npc_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic RSP_ERR_NONE  = 1'b0;
  localparam logic RSP_ERR_RANGE = 1'b1;

  localparam int CNT_W = 4;

  // Replace only the byte lanes whose mask bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Byte-maskable word storage.
//   clk      : clock, write committed on rising edge
//   we_i     : write enable
//   waddr_i  : write word index
//   wdata_i  : write data
//   wmask_i  : byte enables, bit i = byte lane i
//   raddr_i  : read word index
//   rdata_o  : combinational read data
// Contents are not reset.
module mem_array
  import npc_mem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 1024,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       wmask_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= byte_merge(mem_q[waddr_i], wdata_i, wmask_i);
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with valid/ready request and
// response channels and a fixed, parameterised response latency.
//   clk        : clock
//   rst        : asynchronous active-low reset
//   req_valid  : request present          req_ready : request can be accepted
//   req_wen    : 1 = write, 0 = read      req_addr  : byte address
//   req_wdata  : write data               req_wmask : byte enables
//   rsp_valid  : response present         rsp_ready : response accepted
//   rsp_rdata  : read data (0 for writes and errors)
//   rsp_err    : address out of range
// Writes and read sampling both happen on the accepting edge; the response
// is then delayed by LATENCY cycles before being presented.
module mem_responder
  import npc_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int               IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0]      SPAN     = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [CNT_W-1:0] LAT_LOAD = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic [32:0]      off_d;
  logic             in_range_d;
  logic             accept_d;
  logic             mem_we_d;
  logic [IDX_W-1:0] idx_d;
  logic [31:0]      mem_rdata;

  // 33-bit subtraction: a borrow into bit 32 means the address is below
  // BASE_ADDR, and the upper bound cannot wrap around 2^32.
  assign off_d      = {1'b0, req_addr} - {1'b0, BASE_ADDR};
  assign in_range_d = !off_d[32] && (off_d < SPAN);
  assign idx_d      = off_d[IDX_W+1:2];

  assign accept_d = (state_q == ST_IDLE) && req_valid;
  assign mem_we_d = accept_d && req_wen && in_range_d;

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem (
    .clk    (clk),
    .we_i   (mem_we_d),
    .waddr_i(idx_d),
    .wdata_i(req_wdata),
    .wmask_i(req_wmask),
    .raddr_i(idx_d),
    .rdata_o(mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= RSP_ERR_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            // Response payload is captured now, so later req_* changes or
            // writes cannot alter it.
            err_q   <= in_range_d ? RSP_ERR_NONE : RSP_ERR_RANGE;
            rdata_q <= (in_range_d && !req_wen) ? mem_rdata : 32'h0;
            if (LATENCY == 0) begin
              state_q <= ST_RESP;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= LAT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            err_q   <= RSP_ERR_NONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // LATENCY=2 instance
  logic        a_valid = 1'b0, a_ready, a_wen = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic [3:0]  a_mask = '0;
  logic        a_rsp_valid, a_rsp_ready = 1'b0, a_err;
  logic [31:0] a_rdata;

  // LATENCY=0 instance
  logic        b_valid = 1'b0, b_ready, b_wen = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic [3:0]  b_mask = '0;
  logic        b_rsp_valid, b_rsp_ready = 1'b0, b_err;
  logic [31:0] b_rdata;

  mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(a_valid), .req_ready(a_ready), .req_wen(a_wen),
    .req_addr(a_addr), .req_wdata(a_wdata), .req_wmask(a_mask),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rdata), .rsp_err(a_err)
  );

  mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_ready(b_ready), .req_wen(b_wen),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_wmask(b_mask),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rdata), .rsp_err(b_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference memory contents of the LATENCY=2 instance, keyed by word index.
  logic [31:0] mdl [int unsigned];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit mdl_hit(input logic [31:0] a);
    longint unsigned la;
    la = 64'(a);
    return (la >= 64'(BASE)) && (la < 64'(BASE) + 64'(4 * DEPTH));
  endfunction

  function automatic logic [31:0] merged(input logic [31:0] old_w, input logic [31:0] nw,
                                         input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // One complete transaction on the LATENCY=2 instance. While the responder
  // is busy, req_valid stays high with scrambled in-range write requests that
  // must be ignored.
  task automatic txn(input string tag, input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] mask, input int hold);
    bit          hit;
    int unsigned idx;
    logic [31:0] exp_rd, r0;
    logic        exp_err, e0;
    int          n;
    hit     = mdl_hit(addr);
    idx     = (addr - BASE) >> 2;
    exp_err = !hit;
    exp_rd  = (hit && !wen) ? (mdl.exists(idx) ? mdl[idx] : 32'hx) : 32'h0;
    if (hit && wen) mdl[idx] = merged(mdl.exists(idx) ? mdl[idx] : 32'hx, wdata, mask);

    @(negedge clk);
    check({tag, " req_ready idle"}, 32'(a_ready), 32'd1);
    a_valid = 1'b1; a_wen = wen; a_addr = addr; a_wdata = wdata; a_mask = mask;
    @(posedge clk);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      a_wen = 1'b1; a_mask = 4'hF; a_wdata = $urandom;
      a_addr = BASE + 4 * $urandom_range(0, 7);
      if (a_rsp_valid) break;
    end
    check({tag, " latency"}, 32'(n), 32'(LAT + 1));
    check({tag, " rdata"}, a_rdata, exp_rd);
    check({tag, " err"}, 32'(a_err), 32'(exp_err));
    r0 = a_rdata; e0 = a_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, " hold rsp_valid"}, 32'(a_rsp_valid), 32'd1);
      check({tag, " hold rdata"}, a_rdata, r0);
      check({tag, " hold err"}, 32'(a_err), 32'(e0));
      check({tag, " hold req_ready"}, 32'(a_ready), 32'd0);
    end
    a_valid = 1'b0;
    a_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_rsp_ready = 1'b0;
    check({tag, " done rsp_valid"}, 32'(a_rsp_valid), 32'd0);
    check({tag, " done req_ready"}, 32'(a_ready), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    int          r, seen, acc, rsp;

    // Reset state
    #2;
    check("reset req_ready", 32'(a_ready), 32'd1);
    check("reset rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("reset rdata", a_rdata, 32'h0);
    check("reset err", 32'(a_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Full write then read
    txn("wr deadbeef", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0);
    txn("rd deadbeef", 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0);
    check("deadbeef value", a_rdata === 32'h0 ? mdl[4] : 32'h0, 32'hDEAD_BEEF);

    // Partial write merges lanes 0 and 2
    txn("wr mask5", 1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, 0);
    txn("rd mask5", 1'b0, 32'h8000_0012, 32'h0, 4'h0, 0);
    check("mask5 model", mdl[4], 32'hDE22_BE44);

    // Empty mask is a no-op write
    txn("wr mask0", 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 0);
    txn("rd mask0", 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0);

    // Range boundaries
    txn("wr word0", 1'b1, 32'h8000_0000, 32'h0123_4567, 4'hF, 0);
    txn("rd below", 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0);
    txn("rd above", 1'b0, 32'h8000_1000, 32'h0, 4'h0, 0);
    txn("wr above", 1'b1, 32'h8000_1000, 32'hBAD0_BAD0, 4'hF, 0);
    txn("rd word0", 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0);
    txn("rd last", 1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 0);

    // Backpressure held for 5 cycles
    txn("rd stall", 1'b0, 32'h8000_0010, 32'h0, 4'h0, 5);

    // Randomised traffic over a small working set plus out-of-range hits
    for (int i = 0; i < 8; i++) txn("rnd init", 1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 0);
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      addr = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 255));
      else if (r == 1) addr = BASE - 32'(4 * (1 + $urandom_range(0, 255)));
      else             addr = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      txn("rnd", 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 2));
    end

    // Reset while waiting drops the response but keeps the committed write
    @(negedge clk);
    a_valid = 1'b1; a_wen = 1'b1; a_addr = 32'h8000_0020; a_wdata = 32'hCAFE_F00D; a_mask = 4'hF;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    check("rstwait busy", 32'(a_ready), 32'd0);
    #1 rst = 1'b0;
    #1;
    check("rstwait async ready", 32'(a_ready), 32'd1);
    check("rstwait rsp_valid", 32'(a_rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mdl[8] = 32'hCAFE_F00D;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_rsp_valid) seen++;
    end
    check("rstwait no response", 32'(seen), 32'd0);
    txn("rd cafef00d", 1'b0, 32'h8000_0020, 32'h0, 4'h0, 0);

    // LATENCY=0 instance: response in the cycle after acceptance
    @(negedge clk);
    b_valid = 1'b1; b_wen = 1'b1; b_addr = BASE; b_wdata = 32'h0BAD_CAFE; b_mask = 4'hF;
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0;
    check("lat0 rsp_valid", 32'(b_rsp_valid), 32'd1);
    check("lat0 req_ready", 32'(b_ready), 32'd0);
    check("lat0 wr rdata", b_rdata, 32'h0);
    b_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("lat0 done", 32'(b_rsp_valid), 32'd0);

    // Back-to-back reads with req_valid held high
    b_valid = 1'b1; b_wen = 1'b0; b_addr = BASE;
    acc = 0; rsp = 0;
    for (int k = 0; k < 10; k++) begin
      if (b_ready) acc++;
      @(posedge clk);
      @(negedge clk);
      check("lat0 b2b phase", 32'(b_rsp_valid), 32'((k % 2) == 0));
      if (b_rsp_valid) begin
        rsp++;
        check("lat0 b2b rdata", b_rdata, 32'h0BAD_CAFE);
      end
    end
    b_valid = 1'b0; b_rsp_ready = 1'b0;
    check("lat0 b2b accepts", 32'(acc), 32'd5);
    check("lat0 b2b responses", 32'(rsp), 32'd5);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
